// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder: one active and one pending {A,B} slot, LSB-first shift, one GAP cycle per word.
// Optional macro SERIAL_FEEDER_SUB_EN adds in_sub, which stores B negated so the downstream adder produces A-B.
module serial_operand_feeder #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef SERIAL_FEEDER_SUB_EN
  input  logic         in_sub,
`endif
  output logic         start,
  output logic         a,
  output logic         b,
  output logic         busy
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  act_a_reg, act_b_reg;
  logic [W-1:0]  pend_a_reg, pend_b_reg;
  logic          pend_valid_reg;
  logic [W-1:0]  b_eff;
  logic          xfer, load_act, load_pend, pend_fill;

`ifdef SERIAL_FEEDER_SUB_EN
  // Two's-complement negate; the most negative value wraps onto itself.
  assign b_eff = in_sub ? (~in_b + W'(1)) : in_b;
`else
  assign b_eff = in_b;
`endif

  assign in_ready  = !pend_valid_reg;
  assign xfer      = in_valid && in_ready && !rst;
  // A pair goes straight to active only when it is loaded on this very edge.
  assign pend_fill = xfer && !load_act;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_act   = 1'b0;
    load_pend  = 1'b0;
    unique case (state_reg)
      IDLE, GAP: begin
        if (pend_valid_reg) begin
          state_next = SHIFT;
          load_act   = 1'b1;
          load_pend  = 1'b1;
        end else if (xfer) begin
          state_next = SHIFT;
          load_act   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_reg == LAST) state_next = GAP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    busy  = 1'b0;
    unique case (state_reg)
      SHIFT: begin
        start = (cnt_reg == '0);
        a     = act_a_reg[cnt_reg];
        b     = act_b_reg[cnt_reg];
        busy  = 1'b1;
      end
      GAP:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      if (load_act)
        cnt_reg <= '0;
      else if (state_reg == SHIFT)
        cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
      if (load_pend)
        pend_valid_reg <= 1'b0;
      else if (pend_fill)
        pend_valid_reg <= 1'b1;
    end
  end

  // Operand storage only changes on load edges, so the word is frozen through GAP.
  always_ff @(posedge clk) begin
    if (load_act) begin
      act_a_reg <= load_pend ? pend_a_reg : in_a;
      act_b_reg <= load_pend ? pend_b_reg : b_eff;
    end
    if (pend_fill) begin
      pend_a_reg <= in_a;
      pend_b_reg <= b_eff;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: schedule-based model of word start times, per-cycle compare, directed scenarios.
module tb_serial_operand_feeder;
  localparam int W = 6;
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, start, a, b, busy;
  logic [W-1:0] in_a, in_b;
`ifdef SERIAL_FEEDER_SUB_EN
  logic         in_sub;
`endif

  always #5 clk = ~clk;

  serial_operand_feeder #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef SERIAL_FEEDER_SUB_EN
    .in_sub   (in_sub),
`endif
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit started = 0;

  // Model: each accepted word gets a start cycle; everything else follows from that schedule.
  int           w_t[$], w_s[$], w_end[$];
  logic [W-1:0] w_a[$], w_b[$];
  int           last_s = -1000;
  bit           last_acc;

  // Serial words as seen on the DUT pins.
  int           start_cyc[$];
  logic [W-1:0] got_a[$], got_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic bit model_ready(input int c);
    for (int i = 0; i < w_s.size(); i++)
      if (c < w_end[i] && c >= w_t[i] && c < w_s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic expect_at(input int c, output logic es, output logic ea, output logic eb,
                           output logic ebusy, output logic erdy);
    logic [W-1:0] wa, wb;
    es = 0; ea = 0; eb = 0; ebusy = 0;
    erdy = model_ready(c);
    for (int i = 0; i < w_s.size(); i++) begin
      if (c < w_end[i] && c >= w_s[i] && c <= w_s[i] + W) begin
        ebusy = 1;
        if (c < w_s[i] + W) begin
          wa = w_a[i];
          wb = w_b[i];
          es = (c == w_s[i]);
          ea = wa[c - w_s[i]];
          eb = wb[c - w_s[i]];
        end
      end
    end
  endtask

  task automatic model_edge();
    int e;
    int s;
    logic [W-1:0] bv;
    e = cyc + 1;
    last_acc = 0;
    if (rst) begin
      for (int i = 0; i < w_end.size(); i++)
        if (w_end[i] > e) w_end[i] = e;
      last_s = -1000;
    end else if (in_valid && model_ready(cyc)) begin
      s = (e > last_s + W + 1) ? e : last_s + W + 1;
      bv = in_b;
`ifdef SERIAL_FEEDER_SUB_EN
      if (in_sub) bv = -in_b;
`endif
      w_t.push_back(e); w_s.push_back(s); w_end.push_back(NEVER);
      w_a.push_back(in_a); w_b.push_back(bv);
      last_s = s;
      last_acc = 1;
      $display("accept edge %0d A=%0h B=%0h start_cycle=%0d", e, in_a, bv, s);
    end
    cyc = e;
    started = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Offer one pair until taken; returns the number of edges it took.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, output int waited);
    in_a = va; in_b = vb; in_valid = 1;
    waited = 0;
    last_acc = 0;
    while (!last_acc && waited < 20) begin
      step();
      waited++;
    end
    in_valid = 0;
    if (!last_acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_a = W'($urandom); in_b = W'($urandom);
      step();
    end
  endtask

  // Per-cycle compare against the model, plus capture of serial words off the pins.
  initial begin
    logic es, ea, eb, ebz, er;
    logic [W-1:0] ca, cb;
    int cn;
    bit con;
    con = 0; cn = 0; ca = 0; cb = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        expect_at(cyc, es, ea, eb, ebz, er);
        check("start", start, es);
        check("a", a, ea);
        check("b", b, eb);
        check("busy", busy, ebz);
        check("in_ready", in_ready, er);
        if (busy !== 1'b1) con = 0;
        if (start === 1'b1) begin
          start_cyc.push_back(cyc);
          con = 1; cn = 0;
        end
        if (con) begin
          ca[cn] = a; cb[cn] = b;
          cn++;
          if (cn == W) begin
            got_a.push_back(ca); got_b.push_back(cb);
            con = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, e0, n0, g0;
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic [63:0] pat;
    rst = 1; in_valid = 0; in_a = 0; in_b = 0;
`ifdef SERIAL_FEEDER_SUB_EN
    in_sub = 0;
`endif
    step(); step();
    rst = 0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 1);
    check("reset_start", start, 0);

    // Single word; inputs toggle afterwards and must not disturb the shifted word.
    send(6'h2B, 6'h05, w);
    e0 = cyc;
    idle(10);
    check("single_nwords", got_a.size(), 1);
    if (got_a.size() >= 1) begin
      check("single_a_bits", got_a[0], 6'h2B);
      check("single_b_bits", got_b[0], 6'h05);
      check("single_latency", start_cyc[0], e0);
    end
    check("single_idle_busy", busy, 0);

    // Back-to-back with in_valid held high.
    va[0] = 6'h11; vb[0] = 6'h3F;
    va[1] = 6'h2A; vb[1] = 6'h15;
    va[2] = 6'h00; vb[2] = 6'h21;
    n0 = start_cyc.size(); g0 = got_a.size();
    for (int k = 0; k < 3; k++) begin
      send(va[k], vb[k], w);
      if (k == 2) check("backpressure_wait", w, W + 1);
    end
    idle(25);
    check("b2b_nstarts", start_cyc.size(), n0 + 3);
    if (start_cyc.size() >= n0 + 3) begin
      check("b2b_gap01", start_cyc[n0+1] - start_cyc[n0], W + 1);
      check("b2b_gap12", start_cyc[n0+2] - start_cyc[n0+1], W + 1);
    end
    if (got_a.size() >= g0 + 3)
      for (int k = 0; k < 3; k++) begin
        check("b2b_a_word", got_a[g0+k], va[k]);
        check("b2b_b_word", got_b[g0+k], vb[k]);
      end

    // Reset mid-word with pending full.
    send(6'h3C, 6'h0F, w);
    send(6'h15, 6'h2A, w);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    n0 = start_cyc.size();
    idle(15);
    check("midrst_no_replay", start_cyc.size(), n0);
    send(6'h07, 6'h38, w);
    idle(10);
    check("midrst_new_word", start_cyc.size(), n0 + 1);

    // Directed valid pattern exercising IDLE/GAP accepts and pending refills.
    pat = 64'hF0F3_0E1C_96A5_FFFF;
    for (int i = 0; i < 64; i++) begin
      in_valid = pat[i];
      in_a = W'(i * 7);
      in_b = W'(i * 13 + 5);
`ifdef SERIAL_FEEDER_SUB_EN
      in_sub = pat[(i + 3) % 64];
`endif
      step();
    end
    in_valid = 0;
    idle(20);

`ifdef SERIAL_FEEDER_SUB_EN
    g0 = got_b.size();
    in_sub = 1;
    send(6'd9, 6'd3, w);
    send(6'd1, 6'b100000, w);
    in_sub = 0;
    idle(20);
    if (got_b.size() >= g0 + 2) begin
      check("sub_b_bits", got_b[g0], 6'b111101);
      check("sub_wrap", got_b[g0+1], 6'b100000);
    end else check("sub_nwords", got_b.size(), g0 + 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 The block SHALL have parameter W, default 6, meaning the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  a parallel operand pair is offered.
REQ-005 The block SHALL have port in_ready  output  1  the block can accept a pair this cycle.
REQ-006 The block SHALL have port in_a  input  W  operand A, two's complement.
REQ-007 The block SHALL have port in_b  input  W  operand B, two's complement.
REQ-008 The block SHALL have port start  output  1  one-cycle pulse marking the cycle that carries bit 0.
REQ-009 The block SHALL have port a  output  1  serial operand A bit, LSB first.
REQ-010 The block SHALL have port b  output  1  serial operand B bit, LSB first.
REQ-011 The block SHALL have port busy  output  1  a serial word is in flight or a gap cycle is in progress.

Function
REQ-012 Storage SHALL be one active register and one pending register, each holding {A,B}.
REQ-013 A transfer SHALL occur on a rising edge when in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be 1 exactly when the pending register is empty, combinationally from state only, with no dependence on in_valid.
REQ-015 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-016 IDLE transitions: IDLE SHALL go to SHIFT when a pair is accepted or the pending register is full, loading active and clearing bit counter to 0.
REQ-017 In SHIFT, start SHALL be 1 only when the counter is 0; a and b SHALL equal active bit [counter]; the counter SHALL increment each cycle.
REQ-018 SHIFT SHALL go to GAP after the cycle with counter = W-1.
REQ-019 GAP SHALL last exactly one cycle with start=0, a=0, b=0, giving the downstream adder its result/done cycle.
REQ-020 GAP exit: if pending is full, or a pair is accepted during GAP, GAP SHALL go to SHIFT with that pair loaded (pending first); otherwise GAP SHALL go to IDLE.
REQ-021 Latency: a pair accepted at edge t into an empty block SHALL produce start=1 and bit 0 in the cycle after edge t.
REQ-022 Back-to-back throughput SHALL be one word per W+1 cycles; consecutive start pulses SHALL be exactly W+1 cycles apart.
REQ-023 A pair accepted while SHIFT or GAP is active SHALL go to pending; a pair accepted in the same edge that pending drains into active SHALL go to pending.
REQ-024 Active register contents SHALL be frozen from load until the end of the GAP cycle, regardless of in_a/in_b changes.
REQ-025 In IDLE, start, a and b SHALL be 0 and busy SHALL be 0; busy SHALL be 1 in SHIFT and GAP.
REQ-026 Input values SHALL be sampled only on the transfer edge.

Reset
REQ-027 While rst is high at a rising edge, the FSM SHALL enter IDLE, the counter SHALL become 0, and pending SHALL be emptied.
REQ-028 While rst is high at a rising edge, the outputs after that edge SHALL be start=0, a=0, b=0, busy=0 and in_ready=1.
REQ-029 Reset asserted mid-word SHALL abort the word; the partially shifted word and any pending pair SHALL be discarded and never replayed.
REQ-030 A transfer SHALL NOT occur on an edge where rst is high.

Configuration
REQ-031 When macro SERIAL_FEEDER_SUB_EN is defined, the block SHALL have an extra port in_sub  input  1, stored with each pair.
REQ-032 When in_sub=1 and SERIAL_FEEDER_SUB_EN is defined, B SHALL be stored as (~in_b + 1) mod 2^W, so the downstream adder yields A-B.
REQ-033 When SERIAL_FEEDER_SUB_EN is defined, negating the most negative value SHALL wrap, for example W=6 with B=6'b100000 stores 6'b100000.
REQ-034 When SERIAL_FEEDER_SUB_EN is undefined, in_sub SHALL not exist and B SHALL be stored unmodified.

Verification
REQ-035 Scenario, single word: W=6, accept A=6'h2B, B=6'h05 at edge 0 -> start=1 in cycle 1; a=1,1,0,1,0,1 and b=1,0,1,0,0,0 in cycles 1-6; GAP in cycle 7; IDLE in cycle 8.
REQ-036 Scenario, back-to-back: in_valid held high with 3 pairs -> start pulses in cycles 1, 8 and 15.
REQ-037 Scenario, backpressure: in_ready=0 from the edge after the second accept until the edge where pending drains at the end of GAP.
REQ-038 Scenario, reset mid-word: rst high in cycle 3 of a word with pending full -> next cycle IDLE, busy=0, in_ready=1, and no start pulse until a new accept.
REQ-039 Scenario, subtraction with SERIAL_FEEDER_SUB_EN defined: A=6'd9, B=6'd3, in_sub=1 -> b serial bits are those of 6'b111101, LSB first.
REQ-040 Scenario, input stability: in_a/in_b toggled every cycle during SHIFT -> serial a/b bits equal the values captured at the transfer edge.
